// File: rtl/ahb_serial_master_if.sv
// rtl/ahb_serial_master_if.sv - AHB-Lite master bus plus byte-stream rx/tx signals of the serial bridge
interface ahb_serial_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, tx_data, tx_valid, busy,
        input  HRDATA, HREADY, HRESP, rx_data, rx_valid, tx_ready
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, tx_data, tx_valid, busy,
        output HRDATA, HREADY, HRESP, rx_data, rx_valid, tx_ready
    );
endinterface

// File: rtl/ahb_serial_master.sv
// rtl/ahb_serial_master.sv - serial command parser issuing single-word AHB-Lite transfers with byte replies
module ahb_serial_master #(
    parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    ahb_serial_master_if.master        bus
);
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h21;
    localparam logic [7:0] RSP_UNK   = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_ADDR_PH, S_DATA_PH, S_SEND
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  byte_cnt;
    logic [1:0]  reply_cnt;
    logic [31:0] addr_sr;
    logic [31:0] data_sr;
    logic [31:0] reply_sr;
    logic [31:0] timer;
    logic        is_write;
    logic        in_get;
    logic        expired;
    logic        take_byte;
    logic        last_byte;
    logic        known_cmd;

    assign in_get    = (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign expired   = in_get && (timer == TIMEOUT - 32'd1);
    // An rx byte landing on the expiry edge loses to the timeout.
    assign take_byte = bus.rx_valid && !expired && ((state == S_IDLE) || in_get);
    assign last_byte = (byte_cnt == 2'd3);
    assign known_cmd = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (take_byte) begin
                    state_nx = known_cmd ? S_GET_ADDR : S_SEND;
                end
            end
            S_GET_ADDR: begin
                if (expired) begin
                    state_nx = S_IDLE;
                end else if (take_byte && last_byte) begin
                    state_nx = is_write ? S_GET_DATA : S_ADDR_PH;
                end
            end
            S_GET_DATA: begin
                if (expired) begin
                    state_nx = S_IDLE;
                end else if (take_byte && last_byte) begin
                    state_nx = S_ADDR_PH;
                end
            end
            S_ADDR_PH: begin
                if (bus.HREADY) begin
                    state_nx = S_DATA_PH;
                end
            end
            S_DATA_PH: begin
                if (bus.HREADY) begin
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.tx_ready && (reply_cnt == 2'd0)) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.HTRANS   = 2'b00;
        bus.HWRITE   = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.busy     = (state != S_IDLE);
        case (state)
            S_ADDR_PH: begin
                bus.HTRANS = 2'b10;
                bus.HWRITE = is_write;
            end
            S_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = reply_sr[31:24];
            end
            default: ;
        endcase
    end

    assign bus.HADDR  = addr_sr & 32'hFFFF_FFFC;
    assign bus.HWDATA = data_sr;
    assign bus.HSIZE  = 3'b010;

    // Reply bytes leave from the top of reply_sr; reply_cnt holds bytes remaining after the current one.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            byte_cnt  <= 2'd0;
            reply_cnt <= 2'd0;
            addr_sr   <= 32'h0;
            data_sr   <= 32'h0;
            reply_sr  <= 32'h0;
            timer     <= 32'h0;
            is_write  <= 1'b0;
        end else begin
            if (take_byte || !in_get) begin
                timer <= 32'h0;
            end else begin
                timer <= timer + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (take_byte) begin
                        byte_cnt  <= 2'd0;
                        is_write  <= (bus.rx_data == CMD_WRITE);
                        reply_sr  <= {RSP_UNK, 24'h0};
                        reply_cnt <= 2'd0;
                    end
                end
                S_GET_ADDR: begin
                    if (take_byte) begin
                        addr_sr  <= {addr_sr[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_GET_DATA: begin
                    if (take_byte) begin
                        data_sr  <= {data_sr[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_DATA_PH: begin
                    if (bus.HREADY) begin
                        if (bus.HRESP) begin
                            reply_sr  <= {RSP_ERR, 24'h0};
                            reply_cnt <= 2'd0;
                        end else if (is_write) begin
                            reply_sr  <= {RSP_OK, 24'h0};
                            reply_cnt <= 2'd0;
                        end else begin
                            reply_sr  <= bus.HRDATA;
                            reply_cnt <= 2'd3;
                        end
                    end
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        reply_sr  <= {reply_sr[23:0], 8'h00};
                        reply_cnt <= reply_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_serial_master.sv
// tb/tb_ahb_serial_master.sv - self-checking bench for ahb_serial_master
module tb_ahb_serial_master;
    localparam logic [31:0] TO = 32'd64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ahb_serial_master_if bus();
    ahb_serial_master #(.TIMEOUT(TO)) dut (.HCLK(clk), .HRESETn(rstn), .bus(bus.master));

    int checks = 0;
    int errors = 0;

    int          sl_wait = 0;
    bit          sl_err = 0;
    logic [31:0] sl_rdata = 32'h0;
    int          n_xfer = 0;
    logic [31:0] x_addr = 32'h0;
    logic [31:0] x_wdata = 32'h0;
    logic        x_write = 1'b0;
    int          nonseq_cycles = 0;
    logic [7:0]  got[$];
    int          ready_mode = 1;
    int          base_x, base_g, base_ns;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          wt;
        bit          err;
        int          exp_len;
        logic [31:0] exp_reply;
        int          exp_xfer;
        logic [31:0] exp_haddr;
        bit          exp_write;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AHB slave: zero-wait address phase, programmable data-phase wait states and error.
    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        forever begin
            @(negedge clk);
            bus.HRESP  = 1'b0;
            bus.HREADY = 1'b1;
            if (rstn && bus.HTRANS == 2'b10) begin
                n_xfer++;
                x_addr  = bus.HADDR;
                x_write = bus.HWRITE;
                @(negedge clk);
                for (int i = 0; i < sl_wait; i++) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = sl_err && (i == sl_wait - 1);
                    @(negedge clk);
                end
                bus.HREADY = 1'b1;
                bus.HRESP  = sl_err;
                bus.HRDATA = sl_rdata;
                x_wdata    = bus.HWDATA;
            end
        end
    end

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.tx_ready = (ready_mode == 1) ? 1'b1 :
                           (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.HTRANS == 2'b10) nonseq_cycles++;
        if (rstn && bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "/idle"}, bus.busy, 0);
    endtask

    task automatic mark();
        base_x  = n_xfer;
        base_g  = got.size();
        base_ns = nonseq_cycles;
    endtask

    task automatic do_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rd, input int wt, input bit err, input int gap,
                          input string name);
        sl_wait  = wt;
        sl_err   = err;
        sl_rdata = rd;
        mark();
        send_byte(cmd, gap);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], gap);
        if (cmd == 8'h57)
            for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8], gap);
        wait_idle(name);
    endtask

    task automatic verify(input string name, input int exp_len, input logic [31:0] exp_reply,
                          input int exp_xfer, input logic [31:0] exp_haddr, input bit exp_write,
                          input logic [31:0] exp_wdata);
        logic [31:0] act;
        int len;
        act = 32'h0;
        len = got.size() - base_g;
        for (int i = 0; i < len && i < 4; i++) act = {act[23:0], got[base_g + i]};
        check({name, "/reply_len"}, len, exp_len);
        check({name, "/reply"}, act, exp_reply);
        check({name, "/xfers"}, n_xfer - base_x, exp_xfer);
        check({name, "/nonseq_cycles"}, nonseq_cycles - base_ns, exp_xfer);
        if (exp_xfer != 0) begin
            check({name, "/haddr"}, x_addr, exp_haddr);
            check({name, "/hwrite"}, x_write, exp_write);
            if (exp_write) check({name, "/hwdata"}, x_wdata, exp_wdata);
        end
    endtask

    // Reference: reply and transfer derived directly from the command protocol.
    task automatic model(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] rd,
                         input bit err, output int len, output logic [31:0] rep,
                         output int xf, output logic [31:0] ha, output bit wr);
        xf  = (cmd == 8'h57 || cmd == 8'h52) ? 1 : 0;
        wr  = (cmd == 8'h57);
        ha  = addr - (addr % 4);
        if (xf == 0)         begin len = 1; rep = 32'h3F; end
        else if (err)        begin len = 1; rep = 32'h21; end
        else if (wr)         begin len = 1; rep = 32'h4B; end
        else                 begin len = 4; rep = rd;     end
    endtask

    initial begin
        logic [7:0]  d0;
        bit          stable;
        int          n;
        logic [7:0]  c;
        logic [31:0] a, d, r, ha, rep;
        int          wt, len, xf, gap;
        bit          er, wr;

        vt[0] = '{8'h57, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 32'h4B, 1, 32'h0000_0004, 1};
        vt[1] = '{8'h52, 32'h2000_0010, 32'h0, 32'h1234_5678, 2, 0, 4, 32'h1234_5678, 1, 32'h2000_0010, 0};
        vt[2] = '{8'h52, 32'h2000_0007, 32'h0, 32'hCAFE_F00D, 0, 0, 4, 32'hCAFE_F00D, 1, 32'h2000_0004, 0};
        vt[3] = '{8'h57, 32'h0000_0100, 32'h1122_3344, 32'h0, 1, 1, 1, 32'h21, 1, 32'h0000_0100, 1};
        vt[4] = '{8'h41, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h3F, 0, 32'h0, 0};
        vt[5] = '{8'h52, 32'h0000_000C, 32'h0, 32'hA5A5_5A5A, 3, 0, 4, 32'hA5A5_5A5A, 1, 32'h0000_000C, 0};
        vt[6] = '{8'h52, 32'h0000_0008, 32'h0, 32'h5555_5555, 1, 1, 1, 32'h21, 1, 32'h0000_0008, 0};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/HTRANS", bus.HTRANS, 0);
        check("reset/HADDR", bus.HADDR, 0);
        check("reset/HWRITE", bus.HWRITE, 0);
        check("reset/HWDATA", bus.HWDATA, 0);
        check("reset/HSIZE", bus.HSIZE, 3'b010);
        check("reset/tx_valid", bus.tx_valid, 0);
        check("reset/tx_data", bus.tx_data, 0);
        check("reset/busy", bus.busy, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_cmd(vt[i].cmd, vt[i].addr, vt[i].data, vt[i].rdata, vt[i].wt, vt[i].err, 0, nm);
            verify(nm, vt[i].exp_len, vt[i].exp_reply, vt[i].exp_xfer, vt[i].exp_haddr,
                   vt[i].exp_write, vt[i].data);
        end

        // Partial command then silence: aborted without transfer or reply.
        mark();
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("timeout/busy_before", bus.busy, 1);
        repeat (TO + 1) @(negedge clk);
        check("timeout/busy_after", bus.busy, 0);
        check("timeout/nonseq", nonseq_cycles - base_ns, 0);
        check("timeout/tx", got.size() - base_g, 0);
        do_cmd(8'h52, 32'h0000_0030, 32'h0, 32'h0BAD_CAFE, 1, 0, 0, "after_timeout");
        verify("after_timeout", 4, 32'h0BAD_CAFE, 1, 32'h0000_0030, 0, 32'h0);

        do_cmd(8'h57, 32'h0000_0044, 32'h0102_0304, 32'h0, 0, 0, TO - 10, "slow_write");
        verify("slow_write", 1, 32'h4B, 1, 32'h0000_0044, 1, 32'h0102_0304);

        // Transmitter stalled during a read reply; a stray byte meanwhile is ignored.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        sl_wait = 0; sl_err = 0; sl_rdata = 32'h89AB_CDEF;
        mark();
        send_byte(8'h52, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        n = 0;
        while (!bus.tx_valid && n < 100) begin @(negedge clk); n++; end
        check("hold/tx_valid", bus.tx_valid, 1);
        d0 = bus.tx_data;
        stable = 1;
        send_byte(8'h57, 0);
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== d0) stable = 0;
        end
        check("hold/first_byte", d0, 8'h89);
        check("hold/stable", stable, 1);
        ready_mode = 1;
        wait_idle("hold");
        verify("hold", 4, 32'h89AB_CDEF, 1, 32'h0000_0040, 0, 32'h0);
        repeat (5) @(negedge clk);
        check("stray/busy", bus.busy, 0);
        check("stray/nonseq", nonseq_cycles - base_ns, 1);

        // Reset while the slave stretches the data phase.
        sl_wait = 20; sl_err = 0; sl_rdata = 32'h7777_7777;
        mark();
        send_byte(8'h52, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        send_byte(8'h80, 0);
        n = 0;
        while (bus.HTRANS != 2'b10 && n < 50) begin @(negedge clk); n++; end
        check("rst/nonseq_seen", bus.HTRANS, 2'b10);
        @(negedge clk);
        check("rst/busy_in_data", bus.busy, 1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst/HTRANS", bus.HTRANS, 0);
        check("rst/tx_valid", bus.tx_valid, 0);
        check("rst/busy", bus.busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        check("rst/no_tx", got.size() - base_g, 0);
        check("rst/still_idle", bus.busy, 0);

        // Randomized commands against the protocol model.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            string nm;
            n = $urandom_range(0, 9);
            if (n < 4)      c = 8'h57;
            else if (n < 8) c = 8'h52;
            else begin
                c = 8'($urandom);
                while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
            end
            a   = $urandom;
            d   = $urandom;
            r   = $urandom;
            er  = ($urandom_range(0, 3) == 0);
            wt  = $urandom_range(0, 3);
            if (er && wt == 0) wt = 1;
            gap = $urandom_range(0, 5);
            nm  = $sformatf("rand%0d", k);
            model(c, a, r, er, len, rep, xf, ha, wr);
            do_cmd(c, a, d, r, wt, er, gap, nm);
            verify(nm, len, rep, xf, ha, wr, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
